// File: rtl/neuro_uart_rx_if.sv
// neuro_uart_rx_if: received-byte handshake plus error/status lines between the UART receiver and the loader
interface neuro_uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_error;
  logic       rx_overrun;
  logic       rx_busy;
  logic       err_clr;
  modport master (output rx_data, rx_valid, rx_error, rx_overrun, rx_busy, input rx_ready, err_clr);
  modport slave  (input rx_data, rx_valid, rx_error, rx_overrun, rx_busy, output rx_ready, err_clr);
endinterface

// File: rtl/neuro_uart_rx.sv
// neuro_uart_rx: 8N1 serial receiver with bit-centre sampling, valid/ready output and sticky error flags
module neuro_uart_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int SYNC_STAGES  = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic RXD,
  neuro_uart_rx_if.master bus
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d, data_q, data_d;
  logic                   valid_q, valid_d, err_q, err_d, ovr_q, ovr_d, busy_q, busy_d;
  logic                   rxd_s, half_end, bit_end, stop_s, good, bad, load;
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], RXD};
  assign rxd_s    = sync_q[SYNC_STAGES-1];
  assign half_end = cnt_q == CW'(HALF - 1);
  assign bit_end  = cnt_q == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      sync_q  <= '1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: if (half_end) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rxd_s ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        cnt_d          = '0;
        shift_d[bit_q] = rxd_s;
        bit_d          = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (bit_end) begin
        cnt_d   = '0;
        state_d = rxd_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end
  // a good frame only replaces rx_data when the slot is free or being drained this cycle
  assign stop_s = (state_q == STOP) && bit_end;
  assign good   = stop_s && rxd_s;
  assign bad    = stop_s && !rxd_s;
  assign load   = good && (!valid_q || bus.rx_ready);
  always_comb begin
    data_d  = load ? shift_q : data_q;
    valid_d = good || (valid_q && !bus.rx_ready);
    ovr_d   = (good && valid_q && !bus.rx_ready) || (ovr_q && !bus.err_clr);
    err_d   = bad || (err_q && !bus.err_clr);
    busy_d  = state_d != IDLE;
  end
  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.rx_error   = err_q;
  assign bus.rx_overrun = ovr_q;
  assign bus.rx_busy    = busy_q;
endmodule
